// File: rtl/vae_pkg.sv
// Shared definitions for the VAE datapath: word width, vector length and
// the state encoding of the vector streamer.
package vae_pkg;

   localparam int DATA_W  = 16;
   localparam int VEC_LEN = 137;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } vs_state_e;

endpackage

// File: rtl/vec_ram.sv
// Simple dual-port vector memory: one synchronous write port and one
// registered read port. The contents have no reset and are kept across
// reset and frames.
module vec_ram #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 137
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [7:0]       wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [7:0]       rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // Write port and registered read port; the read register holds its value when idle
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/vec_streamer.sv
// Fixed-length vector source: holds one LEN-word vector and, on start,
// streams it out one word per cycle with valid/first/last framing,
// followed by a one-cycle done pulse.
module vec_streamer
   import vae_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int LEN   = VEC_LEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [7:0]       wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             start,
   input  logic             hold,
   output logic [WIDTH-1:0] data_out,
   output logic             valid,
   output logic             first,
   output logic             last,
   output logic             busy,
   output logic             done
);

   localparam logic [8:0] LEN_C  = 9'(LEN);
   localparam logic [8:0] LAST_C = 9'(LEN - 1);

   vs_state_e        state_q, state_d;
   logic [8:0]       idx_q, idx_d;
   logic             valid_q, first_q, last_q;
   logic             beat;
   logic             wr_ok;
   logic [WIDTH-1:0] rd_data;

   // Writes are locked out while a frame is streaming and for out-of-range addresses
   assign wr_ok = wr_en && (state_q != ST_STREAM) && ({1'b0, wr_addr} < LEN_C);

   vec_ram #(
      .WIDTH (WIDTH),
      .DEPTH (LEN)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_ok),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (beat),
      .rd_addr (idx_q[7:0]),
      .rd_data (rd_data)
   );

   // Next-state and beat decision: a beat is issued each unheld STREAM cycle until LEN words are out
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      beat    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_STREAM;
               idx_d   = '0;
            end
         end
         ST_STREAM: begin
            if (idx_q < LEN_C) begin
               if (!hold) begin
                  beat  = 1'b1;
                  idx_d = idx_q + 9'd1;
               end
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // start in the done cycle launches the next frame directly
            if (start) begin
               state_d = ST_STREAM;
               idx_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, index and framing registers; framing lines up with the RAM read register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         valid_q <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         valid_q <= beat;
         first_q <= beat && (idx_q == 9'd0);
         last_q  <= beat && (idx_q == LAST_C);
      end
   end

   // Gaps drive zero so a free-running downstream sum is unaffected
   assign data_out = valid_q ? rd_data : '0;
   assign valid    = valid_q;
   assign first    = first_q;
   assign last     = last_q;
   assign busy     = (state_q == ST_STREAM);
   assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_vec_streamer.sv
// Self-checking bench for vec_streamer: directed frames with a reference
// copy of the vector memory, plus a table of edge-value writes.
module tb_vec_streamer;

   localparam int W = 16;
   localparam int L = 137;

   typedef struct {
      int           addr;
      logic [W-1:0] data;
      int           idx;
      logic [W-1:0] exp;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         wr_en = 1'b0;
   logic [7:0]   wr_addr = '0;
   logic [W-1:0] wr_data = '0;
   logic         start = 1'b0;
   logic         hold = 1'b0;
   logic [W-1:0] data_out;
   logic         valid, first, last, busy, done;

   int n_tests = 0;
   int n_fail  = 0;

   logic [W-1:0] exp_mem [L];
   logic [W-1:0] cap [L];
   vec_t         tbl [5];

   vec_streamer #(.WIDTH(W), .LEN(L)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .start    (start),
      .hold     (hold),
      .data_out (data_out),
      .valid    (valid),
      .first    (first),
      .last     (last),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, " data_out"}, 32'(data_out), 32'd0);
      chk({nm, " valid"},    32'(valid),    32'd0);
      chk({nm, " first"},    32'(first),    32'd0);
      chk({nm, " last"},     32'(last),     32'd0);
      chk({nm, " busy"},     32'(busy),     32'd0);
      chk({nm, " done"},     32'(done),     32'd0);
   endtask

   task automatic wr(input int a, input logic [W-1:0] d);
      wr_en   = 1'b1;
      wr_addr = 8'(a);
      wr_data = d;
      step();
      wr_en = 1'b0;
      if (a < L) exp_mem[a] = d;
   endtask

   // rel counts cycles after the start edge; the DONE cycle is 2+L+hold_n
   task automatic run_frame(input string nm, input int hold_at, input int hold_n,
                            input bit disturb, input bit skip_start, input bit chain);
      int beat = 0;
      int sum = 0;
      int exp_sum = 0;
      int done_rel;
      bit exp_valid;
      done_rel = 2 + L + hold_n;
      for (int k = 0; k < L; k++) exp_sum += int'(exp_mem[k]);
      if (!skip_start) begin
         start = 1'b1;
         step();
         start = 1'b0;
      end
      for (int rel = 1; rel <= done_rel; rel++) begin
         exp_valid = (rel >= 2) && (rel <= 1 + L + hold_n) &&
                     !((hold_n > 0) && (rel >= hold_at + 2) && (rel < hold_at + 2 + hold_n));
         chk({nm, " busy"},  32'(busy),  32'(rel < done_rel));
         chk({nm, " done"},  32'(done),  32'(rel == done_rel));
         chk({nm, " valid"}, 32'(valid), 32'(exp_valid));
         if (valid) begin
            if (beat < L) begin
               chk({nm, " data"},  32'(data_out), 32'(exp_mem[beat]));
               chk({nm, " first"}, 32'(first),    32'(beat == 0));
               chk({nm, " last"},  32'(last),     32'(beat == L - 1));
               cap[beat] = data_out;
            end
            sum += int'(data_out);
            beat++;
         end else begin
            chk({nm, " gap data"}, 32'(data_out), 32'd0);
         end
         hold = (hold_n > 0) && (rel >= hold_at + 1) && (rel <= hold_at + hold_n);
         if (disturb && rel == 40) begin
            start   = 1'b1;
            wr_en   = 1'b1;
            wr_addr = 8'd10;
            wr_data = 16'hFFFF;
         end else begin
            start = 1'b0;
            wr_en = 1'b0;
         end
         if (rel < done_rel) step();
      end
      hold = 1'b0;
      chk({nm, " beats"}, 32'(beat), 32'(L));
      chk({nm, " sum"},   32'(sum),  32'(exp_sum));
      if (chain) begin
         start = 1'b1;
         step();
         start = 1'b0;
      end
   endtask

   initial begin
      tbl[0] = '{addr: 0,   data: 16'h8000, idx: 0,   exp: 16'h8000};
      tbl[1] = '{addr: 1,   data: 16'h7FFF, idx: 1,   exp: 16'h7FFF};
      tbl[2] = '{addr: 136, data: 16'hFFFF, idx: 136, exp: 16'hFFFF};
      tbl[3] = '{addr: 68,  data: 16'h0001, idx: 68,  exp: 16'h0001};
      tbl[4] = '{addr: 137, data: 16'h1234, idx: 135, exp: 16'h0088};

      // reset state
      rst = 1'b1;
      step(); step(); step();
      chk_all_zero("reset");
      rst = 1'b0;

      // load mem[k] = k+1
      for (int k = 0; k < L; k++) wr(k, 16'(k + 1));

      // hold while idle does nothing
      hold = 1'b1;
      step(); step();
      chk("idle hold busy",  32'(busy),  32'd0);
      chk("idle hold valid", 32'(valid), 32'd0);
      hold = 1'b0;

      // plain frame: values 1..137, sum 9453
      run_frame("base", 0, 0, 1'b0, 1'b0, 1'b0);
      chk("base cap0",   32'(cap[0]),   32'd1);
      chk("base cap136", 32'(cap[136]), 32'd137);

      // three hold cycles while element 50 is pending
      run_frame("hold", 50, 3, 1'b0, 1'b0, 1'b0);
      chk("hold cap50", 32'(cap[50]), 32'd51);

      // start and write mid-frame are ignored; next frame starts in the done cycle
      run_frame("disturb", 0, 0, 1'b1, 1'b0, 1'b1);
      run_frame("b2b", 0, 0, 1'b0, 1'b1, 1'b0);
      chk("b2b cap10", 32'(cap[10]), 32'd11);

      // out-of-range write dropped; write together with start lands first
      wr(137, 16'h5555);
      wr_en   = 1'b1;
      wr_addr = 8'd0;
      wr_data = 16'hABCD;
      start   = 1'b1;
      exp_mem[0] = 16'hABCD;
      step();
      wr_en = 1'b0;
      start = 1'b0;
      run_frame("wrstart", 0, 0, 1'b0, 1'b1, 1'b0);
      chk("wrstart cap0", 32'(cap[0]), 32'hABCD);

      // reset while element 60 is visible
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 61; i++) step();
      chk("pre-rst valid", 32'(valid),    32'd1);
      chk("pre-rst data",  32'(data_out), 32'(exp_mem[60]));
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_all_zero("mid rst");
      run_frame("after rst", 0, 0, 1'b0, 1'b0, 1'b0);

      // edge-value table
      for (int i = 0; i < 5; i++) wr(tbl[i].addr, tbl[i].data);
      run_frame("table", 0, 0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("table row %0d", i), 32'(cap[tbl[i].idx]), 32'(tbl[i].exp));
      end

      step();
      chk_all_zero("final idle");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
